rr_arbiter_2ph_clk: RTL and testbench
=====================================

// Module: rr_arbiter_2ph_clk
// PURPOSE
//  Clocked round-robin arbiter that shares one single-rail 2-phase output channel (r/a) between
//  N 2-phase requesters, forwarding the granted requester's data word. It is the synchronous
//  scheduler in front of 2-phase request-combining/merge stages: each req transition is one
//  transaction; exactly one transaction is outstanding on the output channel at any time.
// PARAMETERS
//  N    4  number of requester ports (2..16)
//  DW   8  data word width per requester
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  rst      in   1      asynchronous, active-high reset
//  req_i    in   N      2-phase requests; a transition on bit k = new transaction from port k
//  ack_o    out  N      2-phase acks; bit k toggles once when port k's transaction completes
//  data_i   in   N*DW   port k data at [k*DW +: DW]; held stable while port k is pending
//  r        out  1      2-phase output request; toggles once per issued transaction
//  a        in   1      2-phase output ack from downstream
//  data_o   out  DW     data of granted port; registered, stable from r toggle until a returns
//  grant_o  out  clog2(N)  index of current/last granted port
//  busy_o   out  1      1 while a transaction is outstanding on the output channel
// BEHAVIOUR
//  - Reset (async, immediate): ack_o=0, r=0, data_o=0, grant_o=0, busy_o=0, rr pointer=0, state IDLE.
//    Requesters and downstream must also be in phase 0 after reset; reset mid-transaction
//    abandons it (no ack issued), channel returns to phase 0.
//  - pending[k] = req_i[k] ^ ack_o[k] (combinational). Output outstanding = r ^ a.
//  - FSM two states:
//    IDLE: if |pending: pick first pending port at or after pointer (wrapping N-1 -> 0);
//          at the edge: r<=~r, data_o<=data_i[pick], grant_o<=pick, busy_o<=1, -> BUSY.
//          else stay IDLE.
//    BUSY: when a==r: ack_o[grant_o] toggles, pointer<=grant_o+1 (mod N), busy_o<=0, -> IDLE.
//  - Latency: req toggle before edge k -> r toggles at edge k; a toggle before edge m ->
//    ack_o toggles at edge m. Min 2 cycles per transaction at zero downstream latency.
//  - Fairness: a port pending continuously is served within N transactions.
//  - Simultaneous toggles of several ports: all become pending, served in rr order from pointer.
//  - Requester toggling req again before its ack: protocol violation, behaviour undefined.
//  - a toggling while IDLE (a!=r): protocol violation, ignored until next issue.
//  - pointer wrap: grant N-1 -> pointer 0.
// CONFIGURATION
//  - INPUT_SYNC_EN defined: req_i and a pass through 2-flop synchronizers (reset to 0) before
//    use; pending uses synchronized req; each latency above grows by 2 cycles; data_i must be
//    stable from req toggle to ack (bundled data). Ports fully asynchronous to clk are legal.
//  - INPUT_SYNC_EN undefined: req_i/a must be synchronous to clk; no synchronizer flops.
// STRUCTURE
//  - Shared package async_2ph_pkg: FSM state encoding (ST_IDLE, ST_BUSY), clog2 helper.
//  - Sub-module rr_pick: combinational rotating-priority encoder (pending, pointer -> pick,
//    valid); instantiated once. Top holds FSM, phase registers, data register, synchronizers.
// TESTING
//  1. Reset: assert rst mid-BUSY -> all outputs 0 immediately, FSM IDLE, no ack_o toggle.
//  2. Single port: N=4, toggle req_i[2] with data 8'hA5 -> r toggles next edge, data_o=A5,
//     grant_o=2; toggle a -> ack_o[2] toggles next edge, busy_o=0.
//  3. All four ports toggle same cycle, pointer=0 -> grants 0,1,2,3 in order, one r toggle
//     each, each ack_o bit toggles exactly once, data_o matches each port.
//  4. Fairness: port 0 re-requests immediately after every ack, port 3 pending -> port 3
//     granted no later than 2nd transaction; pointer wraps 3 -> 0.
//  5. Slow downstream: a delayed 10 cycles -> r, data_o, grant_o held constant, new
//     requests queue as pending, no second r toggle until a==r.
//  6. INPUT_SYNC_EN: repeat test 2 -> r toggles 3 edges after req, ack_o 3 edges after a.

Source files
------------

// File: rtl/async_2ph_pkg.sv
// -----------------------------------------------------------------------------
// async_2ph_pkg
// Shared definitions for the 2-phase (transition-signalling) channel blocks:
//   state_t  - arbiter FSM encoding (ST_IDLE, ST_BUSY)
//   clog2    - ceiling log2 used to size index ports (minimum result 1)
// -----------------------------------------------------------------------------
package async_2ph_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Finds the first set bit of
// pending_i at or after position ptr_i, wrapping from N-1 to 0.
// Ports:
//   pending_i [N]   requests to choose from
//   ptr_i     [GW]  highest-priority position
//   pick_o    [GW]  chosen index (0 when nothing is pending)
//   valid_o         1 when any bit of pending_i is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  pending_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] pick_o,
  output logic          valid_o
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest pending port,
  // written last, wins.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (pending_i[idx]) begin
        pick_o  = GW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_2ph_clk.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2ph_clk
// Clocked round-robin arbiter sharing one 2-phase output channel (r/a) among
// N 2-phase requesters. Each req_i transition is one transaction; one
// transaction at a time is outstanding downstream, carrying the granted port's
// data word.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_i  [N]        2-phase requests (transition = new transaction)
//   ack_o  [N]        2-phase acks (toggle once per completed transaction)
//   data_i [N*DW]     port k data at [k*DW +: DW]
//   r                 2-phase output request
//   a                 2-phase output ack from downstream
//   data_o [DW]       registered data of the granted port
//   grant_o[GW]       index of current/last granted port
//   busy_o            1 while a transaction is outstanding downstream
// Build option: define INPUT_SYNC_EN to pass req_i and a through 2-flop
// synchronizers (adds 2 cycles to each latency; inputs may be asynchronous).
// -----------------------------------------------------------------------------
module rr_arbiter_2ph_clk
  import async_2ph_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int GW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    ack_o,
  input  logic [N*DW-1:0] data_i,
  output logic            r,
  input  logic            a,
  output logic [DW-1:0]   data_o,
  output logic [GW-1:0]   grant_o,
  output logic            busy_o
);

  logic [N-1:0] req_s;
  logic         a_s;

`ifdef INPUT_SYNC_EN
  logic [N-1:0] req_s1_q, req_s2_q;
  logic         a_s1_q, a_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1_q <= '0;
      req_s2_q <= '0;
      a_s1_q   <= 1'b0;
      a_s2_q   <= 1'b0;
    end else begin
      req_s1_q <= req_i;
      req_s2_q <= req_s1_q;
      a_s1_q   <= a;
      a_s2_q   <= a_s1_q;
    end
  end

  assign req_s = req_s2_q;
  assign a_s   = a_s2_q;
`else
  assign req_s = req_i;
  assign a_s   = a;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            r_q, r_d;
  logic [DW-1:0]   data_q, data_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    pending;
  logic [GW-1:0]   pick;
  logic            pick_valid;

  // A port has work outstanding while its req and ack phases differ.
  assign pending = req_s ^ ack_q;

  rr_pick #(.N(N), .GW(GW)) u_pick (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .valid_o   (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    r_d     = r_q;
    data_d  = data_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          r_d     = ~r_q;
          data_d  = data_i[pick*DW +: DW];
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Downstream has answered once its ack phase catches up with r.
        if (a_s == r_q) begin
          ack_d[grant_q] = ~ack_q[grant_q];
          ptr_d   = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      r_q     <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      r_q     <= r_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ack_o   = ack_q;
  assign r       = r_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_rr_arbiter_2ph_clk.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_2ph_clk
// Self-checking bench for rr_arbiter_2ph_clk (default build, N=4, DW=8).
// Inputs change on the falling edge; outputs are compared on the falling edge
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_2ph_clk;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N-1:0]    ack_o;
  logic [N*DW-1:0] data_i = '0;
  logic            r;
  logic            a = 1'b0;
  logic [DW-1:0]   data_o;
  logic [GW-1:0]   grant_o;
  logic            busy_o;

  rr_arbiter_2ph_clk #(.N(N), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .ack_o   (ack_o),
    .data_i  (data_i),
    .r       (r),
    .a       (a),
    .data_o  (data_o),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which transactions are owed, whose turn it is, and what
  // the output channel currently carries.
  logic [N-1:0]  m_ack;
  logic          m_r;
  logic [DW-1:0] m_data;
  int            m_grant;
  logic          m_busy;
  int            m_ptr;

  function automatic void model_reset();
    m_ack = '0; m_r = 1'b0; m_data = '0; m_grant = 0; m_busy = 1'b0; m_ptr = 0;
  endfunction

  // Advance the model over one rising edge with the inputs now applied.
  function automatic void model_step();
    int found;
    found = -1;
    if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (found < 0 && (req_i[k] != m_ack[k])) found = k;
      end
      if (found >= 0) begin
        m_r     = ~m_r;
        m_data  = data_i[found*DW +: DW];
        m_grant = found;
        m_busy  = 1'b1;
      end
    end else if (a == m_r) begin
      m_ack[m_grant] = ~m_ack[m_grant];
      m_ptr  = (m_grant + 1) % N;
      m_busy = 1'b0;
    end
  endfunction

  task automatic compare_all(input string pfx);
    check({pfx, "_r"},     32'(r),       32'(m_r));
    check({pfx, "_busy"},  32'(busy_o),  32'(m_busy));
    check({pfx, "_grant"}, 32'(grant_o), 32'(m_grant));
    check({pfx, "_data"},  32'(data_o),  32'(m_data));
    check({pfx, "_ack"},   32'(ack_o),   32'(m_ack));
  endtask

  // Downstream responder and grant log.
  bit   auto_a  = 0;
  int   a_delay = 0;
  int   a_wait  = 0;
  logic r_prev  = 1'b0;
  int   gq[$];

  task automatic tick();
    if (auto_a) begin
      if (r !== a) begin
        if (a_wait >= a_delay) begin a = ~a; a_wait = 0; end
        else a_wait++;
      end else a_wait = 0;
    end
    model_step();
    @(negedge clk);
    compare_all("cyc");
    if (r !== r_prev) begin
      gq.push_back(int'(grant_o));
      $display("issue: grant=%0d data=%02h ack=%b", grant_o, data_o, ack_o);
    end
    r_prev = r;
  endtask

  task automatic toggle_req(input int k, input logic [DW-1:0] d);
    data_i[k*DW +: DW] = d;
    req_i[k] = ~req_i[k];
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; a = 1'b0; data_i = '0;
    model_reset(); r_prev = 1'b0; a_wait = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all("rst");
  endtask

  task automatic run_until(input int n, input int limit, input string tag);
    for (int c = 0; c < limit && gq.size() < n; c++) tick();
    check({tag, "_issues"}, 32'(gq.size()), 32'(n));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Test 1: reset during BUSY clears everything immediately, no ack.
    toggle_req(1, 8'h3C);
    tick();
    check("t1_busy_before", 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset(); r_prev = 1'b0;
    check("t1_r",     32'(r),       32'd0);
    check("t1_busy",  32'(busy_o),  32'd0);
    check("t1_ack",   32'(ack_o),   32'd0);
    check("t1_data",  32'(data_o),  32'd0);
    check("t1_grant", 32'(grant_o), 32'd0);
    do_reset();

    // Test 2: single port, one-edge latency each way.
    toggle_req(2, 8'hA5);
    tick();
    check("t2_r",     32'(r),       32'd1);
    check("t2_data",  32'(data_o),  32'hA5);
    check("t2_grant", 32'(grant_o), 32'd2);
    tick();
    check("t2_hold",  32'(busy_o),  32'd1);
    a = ~a;
    tick();
    check("t2_ack",   32'(ack_o),   32'b0100);
    check("t2_idle",  32'(busy_o),  32'd0);

    // Test 3: all ports at once from pointer 0 -> served 0,1,2,3.
    do_reset(); gq.delete();
    auto_a = 1; a_delay = 0;
    for (int k = 0; k < N; k++) toggle_req(k, DW'(8'h10 + k));
    run_until(4, 40, "t3");
    for (int i = 0; i < 4; i++) check("t3_order", 32'(gq[i]), 32'(i));
    repeat (3) tick();
    check("t3_acks", 32'(ack_o), 32'b1111);

    // Test 4: port 0 re-requests at once; port 3 still gets the 2nd slot,
    // and the pointer wraps back to port 0.
    do_reset(); gq.delete();
    toggle_req(0, 8'h01); toggle_req(3, 8'h33);
    for (int c = 0; c < 40 && gq.size() < 3; c++) begin
      if (req_i[0] == m_ack[0]) toggle_req(0, DW'($urandom));
      tick();
    end
    check("t4_issues", 32'(gq.size()), 32'd3);
    check("t4_first",  32'(gq[0]), 32'd0);
    check("t4_port3",  32'(gq[1]), 32'd3);
    check("t4_wrap",   32'(gq[2]), 32'd0);

    // Test 5: slow downstream holds the channel; queued work waits.
    do_reset(); gq.delete();
    a_delay = 10;
    toggle_req(1, 8'h77);
    tick();
    toggle_req(2, 8'h88);
    for (int c = 0; c < 9; c++) begin
      tick();
      check("t5_r_held",    32'(r),       32'd1);
      check("t5_data_held", 32'(data_o),  32'h77);
      check("t5_grant",     32'(grant_o), 32'd1);
    end
    check("t5_one_issue", 32'(gq.size()), 32'd1);
    run_until(2, 60, "t5");
    check("t5_second", 32'(gq[1]), 32'd2);

    // Random traffic with random downstream latency.
    do_reset(); gq.delete();
    for (int c = 0; c < 800; c++) begin
      a_delay = $urandom_range(0, 3);
      for (int k = 0; k < N; k++)
        if (req_i[k] == m_ack[k] && $urandom_range(0, 99) < 30)
          toggle_req(k, DW'($urandom));
      tick();
    end
    for (int c = 0; c < 100 && (req_i != m_ack || m_busy); c++) tick();
    check("rand_drained", 32'(ack_o), 32'(req_i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
